board_breakpoint_unit: RTL and testbench

//  Multi-slot hardware breakpoint unit for the FPGA board top level. It replaces the single
//  16-bit breakpoint register that is latched from the switches at reset.
//  The operator enters NUM_BP addresses byte by byte from the 8 switches using a debounced

---
 rtl/board_debug_pkg.sv | 18 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/board_breakpoint_unit.sv | 150 +++++++++++++++
 tb/tb_board_breakpoint_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/board_debug_pkg.sv
// Shared definitions for the board-level debug blocks: default sizes, the
// breakpoint load FSM states and the slot-index width helper.
package board_debug_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int NUM_BP_DEF = 4;

  typedef enum logic {
    IDLE,
    FILL
  } load_state_t;

  // A single slot still needs a one-bit index so the ports never collapse to zero width.
  function automatic int slot_w(input int num_bp);
    return (num_bp <= 1) ? 1 : $clog2(num_bp);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, stable-level counter and a
// one-cycle pulse on every accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic i_clk,
  input  logic s_resetn,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // NOTE: every variable gets its default before any branch, so no path can infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        pulse_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge s_resetn) begin
    if (!s_resetn) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], i_btn};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/board_breakpoint_unit.sv
// Multi-slot hardware breakpoint unit: slots are entered byte-wise from the
// switches and every valid slot is compared against each fetched PC in parallel.
module board_breakpoint_unit
  import board_debug_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int NUM_BP          = NUM_BP_DEF,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic                             i_clk,
  input  logic                             s_resetn,
  input  logic [7:0]                       i_switches,
  input  logic                             i_btnLoad,
  input  logic                             i_btnClear,
  input  logic                             i_swEnable,
  input  logic [ADDR_W-1:0]                i_pc,
  input  logic                             i_pcValid,
  input  logic                             i_resume,
  output logic                             o_break,
  output logic [slot_w(NUM_BP)-1:0]        o_hitSlot,
  output logic [slot_w(NUM_BP)-1:0]        o_loadSlot,
  output logic [$clog2(ADDR_W/8):0]        o_loadByte,
  output logic [NUM_BP-1:0]                o_validMask
);

  localparam int SLOT_W = slot_w(NUM_BP);
  localparam int BYTES  = ADDR_W / 8;
  localparam int LB_W   = $clog2(BYTES) + 1;

  logic              load_pulse, clear_pulse;
  logic [1:0]        en_sync_q;
  logic              armed_q, armed_d;
  load_state_t       state_q, state_d;
  logic [ADDR_W-1:0] slot_q [NUM_BP];
  logic [ADDR_W-1:0] slot_d [NUM_BP];
  logic [NUM_BP-1:0] valid_q, valid_d;
  logic [SLOT_W-1:0] load_slot_q, load_slot_d, next_slot;
  logic [LB_W-1:0]   load_byte_q, load_byte_d;
  logic              break_q, break_d;
  logic [SLOT_W-1:0] hit_q, hit_d, hit_idx;
  logic [NUM_BP-1:0] match;
  logic              last_byte;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .i_clk   (i_clk),
    .s_resetn(s_resetn),
    .i_btn   (i_btnLoad),
    .o_pulse (load_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .i_clk   (i_clk),
    .s_resetn(s_resetn),
    .i_btn   (i_btnClear),
    .o_pulse (clear_pulse)
  );

  assign next_slot = (load_slot_q == SLOT_W'(NUM_BP - 1)) ? '0 : load_slot_q + 1'b1;
  assign last_byte = (load_byte_q == LB_W'(BYTES - 1));

  // Compare reads the registered slots, so a same-cycle write is seen only next cycle.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = valid_q[i] & (slot_q[i] == i_pc) & i_pcValid & en_sync_q[1];
    end
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = SLOT_W'(i);
    end
  end

  always_comb begin
    armed_d     = armed_q;
    state_d     = state_q;
    slot_d      = slot_q;
    valid_d     = valid_q;
    load_slot_d = load_slot_q;
    load_byte_d = load_byte_q;
    break_d     = break_q;
    hit_d       = hit_q;

    if (armed_q) begin
      armed_d     = 1'b0;
      slot_d[0]   = ADDR_W'(i_switches);
      valid_d[0]  = 1'b1;
      load_slot_d = (NUM_BP > 1) ? SLOT_W'(1) : '0;
      load_byte_d = '0;
      state_d     = IDLE;
    end else if (clear_pulse) begin
      valid_d     = '0;
      load_slot_d = '0;
      load_byte_d = '0;
      state_d     = IDLE;
    end else if (load_pulse) begin
      for (int b = 0; b < BYTES; b++) begin
        if (load_byte_q == LB_W'(b)) slot_d[load_slot_q][8*b +: 8] = i_switches;
      end
      if (state_q == IDLE) valid_d[load_slot_q] = 1'b0;
      if (last_byte) begin
        valid_d[load_slot_q] = 1'b1;
        load_byte_d          = '0;
        load_slot_d          = next_slot;
        state_d              = IDLE;
      end else begin
        load_byte_d = load_byte_q + 1'b1;
        state_d     = FILL;
      end
    end

    // A new match re-latches only when no break is pending or it is being released.
    if (|match && (!break_q || i_resume)) begin
      break_d = 1'b1;
      hit_d   = hit_idx;
    end else if (i_resume) begin
      break_d = 1'b0;
    end
  end

  // NOTE: the slot array is a small register file and is reset explicitly; a RAM would need a clear sequence instead.
  always_ff @(posedge i_clk or negedge s_resetn) begin
    if (!s_resetn) begin
      en_sync_q   <= '0;
      armed_q     <= 1'b1;
      state_q     <= IDLE;
      for (int i = 0; i < NUM_BP; i++) slot_q[i] <= '0;
      valid_q     <= '0;
      load_slot_q <= '0;
      load_byte_q <= '0;
      break_q     <= 1'b0;
      hit_q       <= '0;
    end else begin
      en_sync_q   <= {en_sync_q[0], i_swEnable};
      armed_q     <= armed_d;
      state_q     <= state_d;
      for (int i = 0; i < NUM_BP; i++) slot_q[i] <= slot_d[i];
      valid_q     <= valid_d;
      load_slot_q <= load_slot_d;
      load_byte_q <= load_byte_d;
      break_q     <= break_d;
      hit_q       <= hit_d;
    end
  end

  assign o_break     = break_q;
  assign o_hitSlot   = hit_q;
  assign o_loadSlot  = load_slot_q;
  assign o_loadByte  = load_byte_q;
  assign o_validMask = valid_q;

endmodule

// File: tb/tb_board_breakpoint_unit.sv
// Directed bench for board_breakpoint_unit with a short debounce window;
// expected values are hand-computed per step.
module tb_board_breakpoint_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        s_resetn;
  logic [7:0]  i_switches;
  logic        i_btnLoad, i_btnClear, i_swEnable;
  logic [15:0] i_pc;
  logic        i_pcValid, i_resume;
  logic        o_break;
  logic [1:0]  o_hitSlot, o_loadSlot, o_loadByte;
  logic [3:0]  o_validMask;

  int n_checks = 0;
  int n_fail   = 0;

  board_breakpoint_unit #(.ADDR_W(16), .NUM_BP(4), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk      (clk),
    .s_resetn   (s_resetn),
    .i_switches (i_switches),
    .i_btnLoad  (i_btnLoad),
    .i_btnClear (i_btnClear),
    .i_swEnable (i_swEnable),
    .i_pc       (i_pc),
    .i_pcValid  (i_pcValid),
    .i_resume   (i_resume),
    .o_break    (o_break),
    .o_hitSlot  (o_hitSlot),
    .o_loadSlot (o_loadSlot),
    .o_loadByte (o_loadByte),
    .o_validMask(o_validMask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [7:0] sw, input logic ld, input logic clr);
    i_switches = sw;
    i_btnLoad  = ld;
    i_btnClear = clr;
    tick(D + 4);
    i_btnLoad  = 1'b0;
    i_btnClear = 1'b0;
    tick(D + 4);
  endtask

  task automatic strobe_pc(input logic [15:0] pc);
    i_pc      = pc;
    i_pcValid = 1'b1;
    tick(1);
    i_pcValid = 1'b0;
  endtask

  task automatic resume_pulse();
    i_resume = 1'b1;
    tick(1);
    i_resume = 1'b0;
  endtask

  initial begin
    s_resetn   = 1'b0;
    i_switches = 8'h3C;
    i_btnLoad  = 1'b0;
    i_btnClear = 1'b0;
    i_swEnable = 1'b1;
    i_pc       = '0;
    i_pcValid  = 1'b0;
    i_resume   = 1'b0;
    tick(2);

    // 1: reset values, power-up capture, first compare
    check("rst_break", o_break, 0);
    check("rst_hit", o_hitSlot, 0);
    check("rst_loadslot", o_loadSlot, 0);
    check("rst_loadbyte", o_loadByte, 0);
    check("rst_mask", o_validMask, 0);
    s_resetn = 1'b1;
    tick(1);
    i_switches = 8'h00;
    check("cap_mask", o_validMask, 4'b0001);
    check("cap_loadslot", o_loadSlot, 1);
    check("cap_loadbyte", o_loadByte, 0);
    tick(2);
    strobe_pc(16'h003C);
    check("cap_break", o_break, 1);
    check("cap_hit", o_hitSlot, 0);
    resume_pulse();
    check("cap_resume", o_break, 0);

    // 2: two-byte load into slot 1, then a short glitch
    press(8'h34, 1'b1, 1'b0);
    check("ld1_byte", o_loadByte, 1);
    check("ld1_mask", o_validMask, 4'b0001);
    press(8'h12, 1'b1, 1'b0);
    check("ld2_mask", o_validMask, 4'b0011);
    check("ld2_slot", o_loadSlot, 2);
    check("ld2_byte", o_loadByte, 0);
    i_switches = 8'hEE;
    i_btnLoad  = 1'b1;
    tick(2);
    i_btnLoad  = 1'b0;
    tick(12);
    check("glitch_byte", o_loadByte, 0);
    check("glitch_slot", o_loadSlot, 2);

    // 3: slots 2 = 5678, 3 = 1234; lowest hit, stickiness, resume
    press(8'h78, 1'b1, 1'b0);
    press(8'h56, 1'b1, 1'b0);
    press(8'h34, 1'b1, 1'b0);
    press(8'h12, 1'b1, 1'b0);
    check("fill_mask", o_validMask, 4'b1111);
    check("wrap_slot", o_loadSlot, 0);
    strobe_pc(16'h1234);
    check("dual_break", o_break, 1);
    check("dual_hit", o_hitSlot, 1);
    tick(5);
    check("sticky_break", o_break, 1);
    strobe_pc(16'h003C);
    check("sticky_hit", o_hitSlot, 1);
    resume_pulse();
    check("resume_fall", o_break, 0);
    strobe_pc(16'h5678);
    check("slot2_hit", o_hitSlot, 2);
    i_resume = 1'b1;
    strobe_pc(16'h003C);
    i_resume = 1'b0;
    check("resume_match_break", o_break, 1);
    check("resume_match_hit", o_hitSlot, 0);
    resume_pulse();

    // 4: wrap overwrites slot 0; partial slot 1 never matches
    press(8'hAA, 1'b1, 1'b0);
    press(8'hBB, 1'b1, 1'b0);
    check("ovw_slot", o_loadSlot, 1);
    strobe_pc(16'h003C);
    check("ovw_old_nobreak", o_break, 0);
    strobe_pc(16'hBBAA);
    check("ovw_new_hit", o_hitSlot, 0);
    check("ovw_new_break", o_break, 1);
    resume_pulse();
    press(8'h55, 1'b1, 1'b0);
    check("part_mask", o_validMask, 4'b1101);
    check("part_byte", o_loadByte, 1);
    strobe_pc(16'h1255);
    check("part_nomatch", o_break, 0);
    strobe_pc(16'h1234);
    check("part_hit3", o_hitSlot, 3);
    resume_pulse();

    // 5: clear beats load; enable gating
    press(8'h99, 1'b1, 1'b1);
    check("clr_mask", o_validMask, 0);
    check("clr_slot", o_loadSlot, 0);
    check("clr_byte", o_loadByte, 0);
    strobe_pc(16'h5678);
    check("clr_nobreak", o_break, 0);
    press(8'h3C, 1'b1, 1'b0);
    press(8'h00, 1'b1, 1'b0);
    check("reld_mask", o_validMask, 4'b0001);
    i_swEnable = 1'b0;
    tick(3);
    strobe_pc(16'h003C);
    check("dis_nobreak", o_break, 0);
    i_swEnable = 1'b1;
    tick(3);
    strobe_pc(16'h003C);
    check("en_break", o_break, 1);
    i_swEnable = 1'b0;
    tick(3);
    check("dis_keeps_break", o_break, 1);

    // 6: reset mid-FILL with a pending break, capture re-arms
    press(8'h77, 1'b1, 1'b0);
    check("mid_fill_byte", o_loadByte, 1);
    i_switches = 8'h5A;
    s_resetn   = 1'b0;
    #1;
    check("rst2_break", o_break, 0);
    check("rst2_loadbyte", o_loadByte, 0);
    check("rst2_loadslot", o_loadSlot, 0);
    check("rst2_mask", o_validMask, 0);
    tick(2);
    i_swEnable = 1'b1;
    s_resetn   = 1'b1;
    tick(1);
    check("cap2_mask", o_validMask, 4'b0001);
    check("cap2_slot", o_loadSlot, 1);
    tick(2);
    strobe_pc(16'h005A);
    check("cap2_break", o_break, 1);
    check("cap2_hit", o_hitSlot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
